// File: rtl/GAM_package.sv
// Shared types for the node allocation scheduler:
// FSM states, op encodings and the default counter table shape.
package GAM_package;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP,
      S_CLR
   } state_t;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_QUERY = 1'b1;

   localparam int DEF_NUM_CLASSES = 16;
   localparam int DEF_CNT_W       = 16;

   typedef logic [DEF_CNT_W-1:0] cnt_tbl_t [DEF_NUM_CLASSES];

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past
// the previous winner and wraps around the request vector.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_winner,
   output logic [ID_W-1:0]    winner,
   output logic               valid
);

   int idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_winner) + k) % NUM_REQ;
         if (!valid && req[ID_W'(idx)]) begin
            valid  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/node_alloc_scheduler.sv
// Shared per-class node counter table; requesters are served one at a
// time (accept, execute, respond) with a saturating allocate or a query.
module node_alloc_scheduler
   import GAM_package::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int NUM_CLASSES = 16,
   parameter  int CNT_W       = 16,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              op,
   input  logic [NUM_REQ-1:0][CLS_W-1:0]   class_id,
   input  logic                            clear,
   output logic [NUM_REQ-1:0]              gnt,
   output logic                            done,
   output logic [ID_W-1:0]                 rsp_id,
   output logic [CNT_W-1:0]                rsp_count,
   output logic                            rsp_sat,
   output logic                            busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state, state_nx;
   logic [ID_W-1:0]   last_winner, win_idx, winner;
   logic              win_vld, op_q, pend_clr, do_clr;
   logic              in_range, accept;
   logic [CLS_W-1:0]  cls_q;
   logic [CNT_W-1:0]  cur_cnt, nxt_cnt;
   logic [CNT_W-1:0]  tbl [NUM_CLASSES];

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req         (req),
      .last_winner (last_winner),
      .winner      (win_idx),
      .valid       (win_vld)
   );

   assign do_clr   = clear | pend_clr;
   assign accept   = (state == S_IDLE) && !do_clr && win_vld;
   assign in_range = (int'(cls_q) < NUM_CLASSES);
   assign busy     = (state != S_IDLE);

   always_comb begin
      cur_cnt = '0;
      if (in_range) cur_cnt = tbl[cls_q];
      nxt_cnt = cur_cnt;
      if (op_q == OP_ALLOC && in_range && cur_cnt != CNT_MAX)
         nxt_cnt = cur_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (do_clr)       state_nx = S_CLR;
            else if (win_vld) state_nx = S_EXEC;
         end
         S_EXEC:  state_nx = S_RESP;
         S_RESP:  state_nx = S_IDLE;
         S_CLR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_winner <= ID_W'(NUM_REQ - 1);
         winner      <= '0;
         op_q        <= OP_ALLOC;
         cls_q       <= '0;
         pend_clr    <= 1'b0;
         gnt         <= '0;
         done        <= 1'b0;
         rsp_id      <= '0;
         rsp_count   <= '0;
         rsp_sat     <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         if (accept) begin
            winner      <= win_idx;
            last_winner <= win_idx;
            op_q        <= op[win_idx];
            cls_q       <= class_id[win_idx];
            gnt         <= NUM_REQ'(1) << win_idx;
         end
         if (state == S_EXEC) begin
            done      <= 1'b1;
            rsp_id    <= winner;
            rsp_count <= nxt_cnt;
            rsp_sat   <= (nxt_cnt == CNT_MAX);
         end
         // a clear seen mid-transaction is parked until the next IDLE
         if (state == S_CLR)
            pend_clr <= 1'b0;
         else if (clear && (state == S_EXEC || state == S_RESP))
            pend_clr <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CLASSES; i++) tbl[i] <= '0;
      end else if (state == S_CLR) begin
         for (int i = 0; i < NUM_CLASSES; i++) tbl[i] <= '0;
      end else if (state == S_EXEC && op_q == OP_ALLOC && in_range) begin
         tbl[cls_q] <= nxt_cnt;
      end
   end

endmodule

// File: tb/tb_node_alloc_scheduler.sv
// Randomized bench for node_alloc_scheduler against a transaction-level
// model; a second narrow instance covers saturation and bad class ids.
module tb_node_alloc_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]       req1 = '0, op1 = '0;
   logic [3:0][3:0]  cls1 = '0;
   logic             clear1 = 1'b0;
   logic [3:0]       gnt1;
   logic             done1, sat1, busy1;
   logic [1:0]       id1;
   logic [15:0]      cnt1;

   logic [3:0]       req2 = '0, op2 = '0;
   logic [3:0][3:0]  cls2 = '0;
   logic             clear2 = 1'b0;
   logic [3:0]       gnt2;
   logic             done2, sat2, busy2;
   logic [1:0]       id2;
   logic [1:0]       cnt2;

   node_alloc_scheduler u_dut (
      .clk(clk), .rst(rst), .req(req1), .op(op1), .class_id(cls1),
      .clear(clear1), .gnt(gnt1), .done(done1), .rsp_id(id1),
      .rsp_count(cnt1), .rsp_sat(sat1), .busy(busy1)
   );

   node_alloc_scheduler #(.NUM_REQ(4), .NUM_CLASSES(12), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .req(req2), .op(op2), .class_id(cls2),
      .clear(clear2), .gnt(gnt2), .done(done2), .rsp_id(id2),
      .rsp_count(cnt2), .rsp_sat(sat2), .busy(busy2)
   );

   int checks = 0;
   int errors = 0;

   // transaction-level model
   int m1 [16];
   int m2 [12];
   int last1, last2;

   function automatic void model_reset();
      foreach (m1[i]) m1[i] = 0;
      foreach (m2[i]) m2[i] = 0;
      last1 = 3;
      last2 = 3;
   endfunction

   function automatic int rr_pick(int last, logic [3:0] r);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   function automatic int svc(int d, bit o, int c);
      if (d == 1) begin
         if (c >= 16) return 0;
         if (!o && m1[c] < 65535) m1[c]++;
         return m1[c];
      end
      if (c >= 12) return 0;
      if (!o && m2[c] < 3) m2[c]++;
      return m2[c];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req1 = '0; req2 = '0; clear1 = 1'b0; clear2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic run_txn(input int d, input int r, input bit o,
                          input int c, output int gc, output int dc,
                          output logic [3:0] gs, output int id,
                          output int cnt, output bit sat);
      gc = -1; dc = -1; gs = '0; id = -1; cnt = -1; sat = 1'b0;
      if (d == 1) begin
         req1[r] = 1'b1; op1[r] = o; cls1[r] = 4'(c);
      end else begin
         req2[r] = 1'b1; op2[r] = o; cls2[r] = 4'(c);
      end
      for (int cyc = 1; cyc <= 20 && dc < 0; cyc++) begin
         @(negedge clk);
         if (d == 1) begin
            if (gnt1 != 0 && gc < 0) begin
               gc = cyc; gs = gnt1; req1[r] = 1'b0;
            end
            if (done1) begin
               dc = cyc; id = int'(id1); cnt = int'(cnt1); sat = sat1;
            end
         end else begin
            if (gnt2 != 0 && gc < 0) begin
               gc = cyc; gs = gnt2; req2[r] = 1'b0;
            end
            if (done2) begin
               dc = cyc; id = int'(id2); cnt = int'(cnt2); sat = sat2;
            end
         end
      end
      if (d == 1) req1[r] = 1'b0;
      else        req2[r] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (gnt1 !== 4'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: gnt=%b done=%b busy=%b, want 0/0/0",
                  gnt1, done1, busy1);
      end
      checks++;
      if (id1 !== 2'd0 || cnt1 !== 16'd0 || sat1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp: id=%0d cnt=%0d sat=%b, want 0/0/0",
                  id1, cnt1, sat1);
      end
      checks++;
      if (gnt2 !== 4'b0 || done2 !== 1'b0 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut2: gnt=%b done=%b busy=%b, want 0/0/0",
                  gnt2, done2, busy2);
      end
   endtask

   task automatic test_single_alloc();
      int gc, dc, id, cnt, e;
      logic [3:0] gs;
      bit sat;
      run_txn(1, 0, 1'b0, 3, gc, dc, gs, id, cnt, sat);
      e = svc(1, 1'b0, 3);
      last1 = 0;
      checks++;
      if (gc !== 1 || gs !== 4'b0001) begin
         errors++;
         $display("FAIL single_gnt: cyc=%0d gnt=%b, want 1 0001", gc, gs);
      end
      checks++;
      if (dc !== 2 || id !== 0 || cnt !== e || sat !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp: cyc=%0d id=%0d cnt=%0d sat=%b, want 2 0 %0d 0",
                  dc, id, cnt, sat, e);
      end
   endtask

   task automatic test_random();
      int gc, dc, id, cnt, e, r, c;
      logic [3:0] gs;
      bit sat, o;
      for (int n = 0; n < 30; n++) begin
         r = int'($urandom_range(0, 3));
         o = 1'($urandom_range(0, 1));
         c = int'($urandom_range(0, 15));
         run_txn(1, r, o, c, gc, dc, gs, id, cnt, sat);
         e = svc(1, o, c);
         last1 = r;
         checks++;
         if (gc !== 1 || gs !== 4'(1 << r)) begin
            errors++;
            $display("FAIL rand_gnt[%0d]: cyc=%0d gnt=%b, want 1 req %0d",
                     n, gc, gs, r);
         end
         checks++;
         if (dc !== 2 || id !== r) begin
            errors++;
            $display("FAIL rand_done[%0d]: cyc=%0d id=%0d, want 2 %0d",
                     n, dc, id, r);
         end
         checks++;
         if (cnt !== e || sat !== 1'b0) begin
            errors++;
            $display("FAIL rand_cnt[%0d]: cnt=%0d sat=%b, want %0d 0",
                     n, cnt, sat, e);
         end
      end
   endtask

   task automatic test_clear_collision();
      int gc, dc, id, cnt, e;
      logic [3:0] gs;
      bit sat, seen_done;
      do_reset();
      req1[0] = 1'b1; op1[0] = 1'b0; cls1[0] = 4'd2;
      gc = -1;
      for (int cyc = 1; cyc <= 10 && gc < 0; cyc++) begin
         @(negedge clk);
         if (gnt1 != 0) begin
            gc = cyc; clear1 = 1'b1; req1[0] = 1'b0;
         end
      end
      @(negedge clk);
      clear1 = 1'b0;
      seen_done = done1;
      cnt = int'(cnt1);
      e = svc(1, 1'b0, 2);
      last1 = 0;
      checks++;
      if (gc !== 1 || seen_done !== 1'b1 || cnt !== e) begin
         errors++;
         $display("FAIL clr_coll_rsp: gcyc=%0d done=%b cnt=%0d, want 1 1 %0d",
                  gc, seen_done, cnt, e);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b1 || gnt1 !== 4'b0 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL clr_pending: busy=%b gnt=%b done=%b, want 1 0 0",
                  busy1, gnt1, done1);
      end
      foreach (m1[i]) m1[i] = 0;
      @(negedge clk);
      run_txn(1, 1, 1'b1, 2, gc, dc, gs, id, cnt, sat);
      e = svc(1, 1'b1, 2);
      last1 = 1;
      checks++;
      if (cnt !== e || gs !== 4'b0010 || dc < 0) begin
         errors++;
         $display("FAIL clr_query: cnt=%0d gnt=%b, want %0d 0010", cnt, gs, e);
      end
      run_txn(1, 2, 1'b0, 9, gc, dc, gs, id, cnt, sat);
      e = svc(1, 1'b0, 9);
      last1 = 2;
      clear1 = 1'b1;
      @(negedge clk);
      clear1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL clr_idle: busy=%b done=%b, want 1 0", busy1, done1);
      end
      foreach (m1[i]) m1[i] = 0;
      @(negedge clk);
      run_txn(1, 3, 1'b1, 9, gc, dc, gs, id, cnt, sat);
      e = svc(1, 1'b1, 9);
      last1 = 3;
      checks++;
      if (cnt !== e || dc !== 2) begin
         errors++;
         $display("FAIL clr_idle_query: cnt=%0d cyc=%0d, want %0d 2", cnt, dc, e);
      end
   endtask

   task automatic test_back_to_back();
      int dcyc [$];
      int e, c, ng;
      c = int'($urandom_range(0, 15));
      ng = 0;
      req1[0] = 1'b1; op1[0] = 1'b0; cls1[0] = 4'(c);
      for (int cyc = 1; cyc <= 30 && dcyc.size() < 3; cyc++) begin
         @(negedge clk);
         if (gnt1 != 0) begin
            ng++;
            checks++;
            if (gnt1 !== 4'b0001) begin
               errors++;
               $display("FAIL b2b_gnt: gnt=%b, want 0001", gnt1);
            end
         end
         if (done1) begin
            e = svc(1, 1'b0, c);
            dcyc.push_back(cyc);
            checks++;
            if (int'(cnt1) !== e) begin
               errors++;
               $display("FAIL b2b_cnt: cnt=%0d, want %0d", cnt1, e);
            end
            if (dcyc.size() == 3) req1[0] = 1'b0;
         end
      end
      last1 = 0;
      checks++;
      if (dcyc.size() != 3 || ng != 3) begin
         errors++;
         $display("FAIL b2b_timeout: dones=%0d gnts=%0d, want 3 3",
                  dcyc.size(), ng);
      end else begin
         checks++;
         if (dcyc[1] - dcyc[0] != 3 || dcyc[2] - dcyc[1] != 3) begin
            errors++;
            $display("FAIL b2b_rate: gaps=%0d,%0d, want 3,3",
                     dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int gc, dc, id, cnt, e;
      logic [3:0] gs;
      bit sat;
      for (int n = 0; n < 4; n++) begin
         run_txn(2, 0, 1'b0, 5, gc, dc, gs, id, cnt, sat);
         e = svc(2, 1'b0, 5);
         last2 = 0;
         checks++;
         if (cnt !== e || sat !== (e == 3) || dc !== 2) begin
            errors++;
            $display("FAIL sat[%0d]: cnt=%0d sat=%b cyc=%0d, want %0d %b 2",
                     n, cnt, sat, dc, e, (e == 3));
         end
      end
   endtask

   task automatic test_out_of_range();
      int gc, dc, id, cnt, e;
      logic [3:0] gs;
      bit sat;
      run_txn(2, 1, 1'b0, 1, gc, dc, gs, id, cnt, sat);
      e = svc(2, 1'b0, 1);
      last2 = 1;
      run_txn(2, 2, 1'b0, 12, gc, dc, gs, id, cnt, sat);
      e = svc(2, 1'b0, 12);
      last2 = 2;
      checks++;
      if (cnt !== e || sat !== 1'b0 || dc !== 2 || id !== 2) begin
         errors++;
         $display("FAIL oor_rsp: cnt=%0d sat=%b cyc=%0d id=%0d, want %0d 0 2 2",
                  cnt, sat, dc, id, e);
      end
      for (int c = 0; c < 12; c++) begin
         run_txn(2, c % 4, 1'b1, c, gc, dc, gs, id, cnt, sat);
         e = svc(2, 1'b1, c);
         last2 = c % 4;
         checks++;
         if (cnt !== e) begin
            errors++;
            $display("FAIL oor_table[%0d]: cnt=%0d, want %0d", c, cnt, e);
         end
      end
   endtask

   task automatic test_reset_midop();
      int gc, dc, id, cnt, e, bad;
      logic [3:0] gs;
      bit sat;
      run_txn(1, 2, 1'b0, 7, gc, dc, gs, id, cnt, sat);
      e = svc(1, 1'b0, 7);
      last1 = 2;
      req1[2] = 1'b1; op1[2] = 1'b0; cls1[2] = 4'd7;
      gc = -1;
      for (int cyc = 1; cyc <= 10 && gc < 0; cyc++) begin
         @(negedge clk);
         if (gnt1 != 0) gc = cyc;
      end
      rst = 1'b1;
      req1 = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bad = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (done1 || gnt1 != 0) bad++;
      end
      checks++;
      if (gc !== 1 || bad !== 0) begin
         errors++;
         $display("FAIL rst_abort: gcyc=%0d stray=%0d, want 1 0", gc, bad);
      end
      req1 = 4'b0011; op1 = 4'b0011; cls1[0] = 4'd7; cls1[1] = 4'd7;
      gs = '0; dc = -1;
      for (int cyc = 1; cyc <= 10 && dc < 0; cyc++) begin
         @(negedge clk);
         if (gnt1 != 0 && gs == 0) begin
            gs = gnt1; req1 = '0;
         end
         if (done1) begin
            dc = cyc; cnt = int'(cnt1); id = int'(id1);
         end
      end
      e = svc(1, 1'b1, 7);
      last1 = 0;
      checks++;
      if (gs !== 4'(1 << rr_pick(3, 4'b0011))) begin
         errors++;
         $display("FAIL rst_first_gnt: gnt=%b, want 0001", gs);
      end
      checks++;
      if (dc < 0 || cnt !== e || id !== 0) begin
         errors++;
         $display("FAIL rst_query: cnt=%0d id=%0d, want %0d 0", cnt, id, e);
      end
      bad = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (gnt1 != 0 || done1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL dropped_req: stray=%0d, want 0", bad);
      end
   endtask

   task automatic test_fairness();
      int cl [4];
      int expq [$];
      int w, e, ndone;
      do_reset();
      foreach (cl[i]) begin
         cl[i] = int'($urandom_range(0, 15));
         cls1[i] = 4'(cl[i]);
      end
      op1 = 4'b0000;
      req1 = 4'b1111;
      ndone = 0;
      for (int cyc = 1; cyc <= 40 && ndone < 5; cyc++) begin
         @(negedge clk);
         if (gnt1 != 0) begin
            w = rr_pick(last1, 4'b1111);
            checks++;
            if (gnt1 !== 4'(1 << w)) begin
               errors++;
               $display("FAIL fair_gnt: gnt=%b, want req %0d", gnt1, w);
            end
            last1 = w;
            expq.push_back(w);
         end
         if (done1) begin
            ndone++;
            if (ndone == 5) req1 = '0;
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL fair_done: done without grant, id=%0d", id1);
            end else begin
               w = expq.pop_front();
               e = svc(1, 1'b0, cl[w]);
               if (int'(id1) !== w || int'(cnt1) !== e) begin
                  errors++;
                  $display("FAIL fair_rsp: id=%0d cnt=%0d, want %0d %0d",
                           id1, cnt1, w, e);
               end
            end
         end
      end
      req1 = '0;
      checks++;
      if (ndone != 5 || last1 != 0) begin
         errors++;
         $display("FAIL fair_count: dones=%0d last=%0d, want 5 0", ndone, last1);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_alloc();
      test_random();
      test_clear_collision();
      test_back_to_back();
      test_saturation();
      test_out_of_range();
      test_reset_midop();
      test_fairness();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
